csr_timer: RTL and testbench

Constant-counter and timer unit for the LoongArch CSR file. Holds TID (0x40), TCFG (0x41), TVAL (0x42) and TICLR (0x44), a free-running 64-bit stable counter for `rdcntvl.w`/`rdcntvh.w`/`rdcntid`, and the timer interrupt source. Sits beside the CSR register file and feeds it:

- `csr_rdata`/`csr_hit` merge into the CSR read mux.
- `timer_int` drives ESTAT.IS[11].
- Writes arrive from the same writeback-stage CSR write port.

---
 rtl/csr_timer.sv | 116 +++++++++++
 tb/tb_csr_timer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/csr_timer.sv
// Purpose : LoongArch CSR timer block: TID/TCFG/TVAL/TICLR, 64-bit stable counter, timer interrupt source.
// Latency : CSR writes take effect at the next edge; csr_rdata is combinational with no write bypass.
// Backpress: none; the write port is a single-cycle strobe and every write is accepted.
module csr_timer #(
   parameter logic [31:0] TID_RESET = 32'h0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        csr_we,
   input  logic [13:0] csr_waddr,
   input  logic [31:0] csr_wmask,
   input  logic [31:0] csr_wdata,
   input  logic [13:0] csr_raddr,
   output logic [31:0] csr_rdata,
   output logic        csr_hit,
   output logic [31:0] cnt_lo,
   output logic [31:0] cnt_hi,
   output logic [31:0] tid,
   output logic        timer_int
);

   localparam logic [13:0] ADDR_TID   = 14'h40;
   localparam logic [13:0] ADDR_TCFG  = 14'h41;
   localparam logic [13:0] ADDR_TVAL  = 14'h42;
   localparam logic [13:0] ADDR_TICLR = 14'h44;

   logic [63:0] cnt_q, cnt_d;
   logic [31:0] tid_q, tid_d;
   logic [31:0] tcfg_q, tcfg_d;
   logic [31:0] tval_q, tval_d;
   logic        timer_int_q, timer_int_d;

   logic        tid_we, tcfg_we, ticlr_clr;
   logic [31:0] tcfg_new;
   logic        tmr_en, tmr_periodic, tval_zero, expire;

   assign tmr_en       = tcfg_q[0];
   assign tmr_periodic = tcfg_q[1];
   assign tval_zero    = (tval_q == 32'h0);

   // Write decode and the masked merge that TCFG would take on this cycle.
   always_comb begin
      tid_we    = csr_we && (csr_waddr == ADDR_TID);
      tcfg_we   = csr_we && (csr_waddr == ADDR_TCFG);
      ticlr_clr = csr_we && (csr_waddr == ADDR_TICLR) && csr_wmask[0] && csr_wdata[0];
      tcfg_new  = (tcfg_q & ~csr_wmask) | (csr_wdata & csr_wmask);
      // A TCFG write in flight suppresses the expiry: the write reloads or freezes TVAL instead.
      expire    = tmr_en && (tval_q == 32'h1) && !tcfg_we;
   end

   // Next-state for counter, TID, TCFG, TVAL and the interrupt latch.
   always_comb begin
      cnt_d  = cnt_q + 64'h1;
      tid_d  = tid_we  ? ((tid_q & ~csr_wmask) | (csr_wdata & csr_wmask)) : tid_q;
      tcfg_d = tcfg_we ? tcfg_new : tcfg_q;

      tval_d = tval_q;
      if (tcfg_we) begin
         if (tcfg_new[0]) begin
            tval_d = {tcfg_new[31:2], 2'b00};
         end
      end else if (tmr_en) begin
         if (!tval_zero) begin
            tval_d = tval_q - 32'h1;
         end else if (tmr_periodic) begin
            tval_d = {tcfg_q[31:2], 2'b00};
         end
         // one-shot at zero: hold until software rewrites TCFG
      end

      // Set beats clear when they coincide so an expiry is never lost.
      if (expire) begin
         timer_int_d = 1'b1;
      end else if (ticlr_clr) begin
         timer_int_d = 1'b0;
      end else begin
         timer_int_d = timer_int_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q       <= 64'h0;
         tid_q       <= TID_RESET;
         tcfg_q      <= 32'h0;
         tval_q      <= 32'hFFFF_FFFF;
         timer_int_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         tid_q       <= tid_d;
         tcfg_q      <= tcfg_d;
         tval_q      <= tval_d;
         timer_int_q <= timer_int_d;
      end
   end

   // Read mux into the CSR file; TICLR hits but always reads zero.
   always_comb begin
      csr_hit   = 1'b0;
      csr_rdata = 32'h0;
      case (csr_raddr)
         ADDR_TID:   begin csr_hit = 1'b1; csr_rdata = tid_q;  end
         ADDR_TCFG:  begin csr_hit = 1'b1; csr_rdata = tcfg_q; end
         ADDR_TVAL:  begin csr_hit = 1'b1; csr_rdata = tval_q; end
         ADDR_TICLR: begin csr_hit = 1'b1; csr_rdata = 32'h0;  end
         default:    begin csr_hit = 1'b0; csr_rdata = 32'h0;  end
      endcase
   end

   assign cnt_lo    = cnt_q[31:0];
   assign cnt_hi    = cnt_q[63:32];
   assign tid       = tid_q;
   assign timer_int = timer_int_q;

endmodule

// File: tb/tb_csr_timer.sv
// Bench for csr_timer: cycle-by-cycle vector table plus hand sequences for reset and counter carry.
// Each vector row drives one cycle and checks the state registered at the previous edge.
module tb_csr_timer;

   logic        clk;
   logic        resetn;
   logic        csr_we;
   logic [13:0] csr_waddr;
   logic [31:0] csr_wmask;
   logic [31:0] csr_wdata;
   logic [13:0] csr_raddr;
   logic [31:0] csr_rdata;
   logic        csr_hit;
   logic [31:0] cnt_lo;
   logic [31:0] cnt_hi;
   logic [31:0] tid;
   logic        timer_int;

   int checks = 0;
   int errors = 0;

   csr_timer #(.TID_RESET(32'h0)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .csr_we    (csr_we),
      .csr_waddr (csr_waddr),
      .csr_wmask (csr_wmask),
      .csr_wdata (csr_wdata),
      .csr_raddr (csr_raddr),
      .csr_rdata (csr_rdata),
      .csr_hit   (csr_hit),
      .cnt_lo    (cnt_lo),
      .cnt_hi    (cnt_hi),
      .tid       (tid),
      .timer_int (timer_int)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [13:0] waddr;
      logic [31:0] wmask;
      logic [31:0] wdata;
      logic [13:0] raddr;
      logic [31:0] exp_rdata;
      logic        exp_hit;
      logic        exp_int;
      logic [31:0] exp_tid;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic we, logic [13:0] waddr, logic [31:0] wmask, logic [31:0] wdata,
                               logic [13:0] raddr, logic [31:0] rd, logic hit, logic irq, logic [31:0] t);
      vec_t v;
      v.we = we; v.waddr = waddr; v.wmask = wmask; v.wdata = wdata; v.raddr = raddr;
      v.exp_rdata = rd; v.exp_hit = hit; v.exp_int = irq; v.exp_tid = t;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Plain read of TVAL with no write this cycle.
   function automatic vec_t rd_tval(logic [31:0] v, logic irq, logic [31:0] t);
      return mk(1'b0, 14'h0, 32'h0, 32'h0, 14'h42, v, 1'b1, irq, t);
   endfunction

   // TICLR clear pulse while reading TVAL.
   function automatic vec_t clr_tval(logic [31:0] v, logic irq, logic [31:0] t);
      return mk(1'b1, 14'h44, 32'h1, 32'h1, 14'h42, v, 1'b1, irq, t);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      resetn    = 1'b0;
      csr_we    = 1'b0;
      csr_waddr = 14'h0;
      csr_wmask = 32'h0;
      csr_wdata = 32'h0;
      csr_raddr = 14'h42;

      // ---------------- one-shot: InitVal = 2, TVAL 8..1,0 then holds ----------------
      vecs.push_back(mk(1'b1, 14'h41, 32'hFFFF_FFFF, 32'h9, 14'h42, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0));
      for (int k = 8; k >= 1; k--) vecs.push_back(rd_tval(k, 1'b0, 32'h0));
      vecs.push_back(rd_tval(32'h0, 1'b1, 32'h0));     // 9 cycles after the write
      vecs.push_back(rd_tval(32'h0, 1'b1, 32'h0));
      vecs.push_back(mk(1'b1, 14'h44, 32'h1, 32'h1, 14'h44, 32'h0, 1'b1, 1'b1, 32'h0));
      vecs.push_back(rd_tval(32'h0, 1'b0, 32'h0));     // cleared
      vecs.push_back(rd_tval(32'h0, 1'b0, 32'h0));     // no re-fire
      // ---------------- periodic: InitVal = 1, period 5 ----------------
      vecs.push_back(mk(1'b1, 14'h41, 32'hFFFF_FFFF, 32'h7, 14'h41, 32'h9, 1'b1, 1'b0, 32'h0));
      vecs.push_back(rd_tval(4, 0, 0)); vecs.push_back(rd_tval(3, 0, 0));
      vecs.push_back(rd_tval(2, 0, 0)); vecs.push_back(rd_tval(1, 0, 0));
      vecs.push_back(clr_tval(0, 1, 0));
      vecs.push_back(rd_tval(4, 0, 0)); vecs.push_back(rd_tval(3, 0, 0));
      vecs.push_back(rd_tval(2, 0, 0)); vecs.push_back(rd_tval(1, 0, 0));
      vecs.push_back(clr_tval(0, 1, 0));
      vecs.push_back(rd_tval(4, 0, 0)); vecs.push_back(rd_tval(3, 0, 0));
      vecs.push_back(rd_tval(2, 0, 0)); vecs.push_back(rd_tval(1, 0, 0));
      vecs.push_back(rd_tval(0, 1, 0));                 // rise, left pending
      vecs.push_back(rd_tval(4, 1, 0)); vecs.push_back(rd_tval(3, 1, 0));
      vecs.push_back(rd_tval(2, 1, 0));
      vecs.push_back(clr_tval(1, 1, 0));                // clear collides with expiry
      vecs.push_back(clr_tval(0, 1, 0));                // set won; clear again
      vecs.push_back(rd_tval(4, 0, 0));
      // ---------------- masked En clear, freeze, re-enable reload ----------------
      vecs.push_back(mk(1'b1, 14'h41, 32'h1, 32'h0, 14'h42, 32'h3, 1'b1, 1'b0, 32'h0));
      vecs.push_back(rd_tval(3, 0, 0));
      vecs.push_back(mk(1'b0, 14'h0, 32'h0, 32'h0, 14'h41, 32'h6, 1'b1, 1'b0, 32'h0));
      vecs.push_back(mk(1'b1, 14'h41, 32'h1, 32'h1, 14'h42, 32'h3, 1'b1, 1'b0, 32'h0));
      vecs.push_back(rd_tval(4, 0, 0));
      // disable, then TVAL write is ignored
      vecs.push_back(mk(1'b1, 14'h41, 32'hFFFF_FFFF, 32'h0, 14'h42, 32'h3, 1'b1, 1'b0, 32'h0));
      vecs.push_back(mk(1'b1, 14'h42, 32'hFFFF_FFFF, 32'h1234_5678, 14'h42, 32'h3, 1'b1, 1'b0, 32'h0));
      vecs.push_back(rd_tval(3, 0, 0));
      // ---------------- TID masked write, unmapped read ----------------
      vecs.push_back(mk(1'b1, 14'h40, 32'hFFFF_0000, 32'hDEAD_BEEF, 14'h40, 32'h0, 1'b1, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 14'h0, 32'h0, 32'h0, 14'h40, 32'hDEAD_0000, 1'b1, 1'b0, 32'hDEAD_0000));
      vecs.push_back(mk(1'b0, 14'h0, 32'h0, 32'h0, 14'h43, 32'h0, 1'b0, 1'b0, 32'hDEAD_0000));
      // ---------------- En = 1 with InitVal = 0: never expires ----------------
      vecs.push_back(mk(1'b1, 14'h41, 32'hFFFF_FFFF, 32'h1, 14'h41, 32'h0, 1'b1, 1'b0, 32'hDEAD_0000));
      vecs.push_back(rd_tval(0, 0, 32'hDEAD_0000));
      vecs.push_back(rd_tval(0, 0, 32'hDEAD_0000));
      vecs.push_back(mk(1'b0, 14'h0, 32'h0, 32'h0, 14'h41, 32'h1, 1'b1, 1'b0, 32'hDEAD_0000));

      // ---------------- reset ----------------
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      #1;
      chk("rst_cnt_lo0", cnt_lo, 0);
      chk("rst_cnt_hi", cnt_hi, 0);
      chk("rst_tval", csr_rdata, 32'hFFFF_FFFF);
      chk("rst_int", timer_int, 0);
      chk("rst_tid", tid, 0);
      csr_raddr = 14'h41;
      #1 chk("rst_tcfg", csr_rdata, 0);
      step(); chk("rst_cnt_lo1", cnt_lo, 1);
      step(); chk("rst_cnt_lo2", cnt_lo, 2);
      step();

      // ---------------- vector table ----------------
      for (int i = 0; i < vecs.size(); i++) begin
         csr_we    = vecs[i].we;
         csr_waddr = vecs[i].waddr;
         csr_wmask = vecs[i].wmask;
         csr_wdata = vecs[i].wdata;
         csr_raddr = vecs[i].raddr;
         #2;
         chk($sformatf("v%0d_rdata", i), csr_rdata, vecs[i].exp_rdata);
         chk($sformatf("v%0d_hit", i), csr_hit, vecs[i].exp_hit);
         chk($sformatf("v%0d_int", i), timer_int, vecs[i].exp_int);
         chk($sformatf("v%0d_tid", i), tid, vecs[i].exp_tid);
         @(posedge clk);
         #1;
      end
      csr_we = 1'b0;

      // ---------------- reset mid-count discards timer state ----------------
      csr_we = 1'b1; csr_waddr = 14'h41; csr_wmask = 32'hFFFF_FFFF; csr_wdata = 32'h15;
      step();
      csr_we = 1'b0;
      step();
      csr_raddr = 14'h42;
      #1 chk("mid_tval_running", csr_rdata, 32'h13);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      #1;
      chk("mid_rst_tval", csr_rdata, 32'hFFFF_FFFF);
      chk("mid_rst_tid", tid, 0);
      chk("mid_rst_cnt", cnt_lo, 0);
      chk("mid_rst_int", timer_int, 0);
      csr_raddr = 14'h41;
      #1 chk("mid_rst_tcfg", csr_rdata, 0);

      // ---------------- counter carry via backdoor ----------------
      dut.cnt_q = 64'h0000_0000_FFFF_FFFE;
      step();
      chk("carry_a", {cnt_hi, cnt_lo}, 64'h0000_0000_FFFF_FFFF);
      step();
      chk("carry_b", {cnt_hi, cnt_lo}, 64'h0000_0001_0000_0000);
      step();
      chk("carry_c", {cnt_hi, cnt_lo}, 64'h0000_0001_0000_0001);
      csr_raddr = 14'h43;
      #1;
      chk("unmapped_hit", csr_hit, 0);
      chk("unmapped_rdata", csr_rdata, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
